// File: rtl/axi4_slave_mem.sv
// AXI4 responder backed by a word-addressed RAM.
// Independent read and write channels, one burst outstanding per direction.
module axi4_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_awaddr,
    input  logic [7:0]                S_AXI_awlen,
    input  logic [2:0]                S_AXI_awsize,
    input  logic [1:0]                S_AXI_awburst,
    input  logic                      S_AXI_awvalid,
    output logic                      S_AXI_awready,
    input  logic [DATA_WIDTH-1:0]     S_AXI_wdata,
    input  logic [DATA_WIDTH/8-1:0]   S_AXI_wstrb,
    input  logic                      S_AXI_wlast,
    input  logic                      S_AXI_wvalid,
    output logic                      S_AXI_wready,
    output logic [1:0]                S_AXI_bresp,
    output logic                      S_AXI_bvalid,
    input  logic                      S_AXI_bready,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_araddr,
    input  logic [7:0]                S_AXI_arlen,
    input  logic [2:0]                S_AXI_arsize,
    input  logic [1:0]                S_AXI_arburst,
    input  logic                      S_AXI_arvalid,
    output logic                      S_AXI_arready,
    output logic [DATA_WIDTH-1:0]     S_AXI_rdata,
    output logic [1:0]                S_AXI_rresp,
    output logic                      S_AXI_rlast,
    output logic                      S_AXI_rvalid,
    input  logic                      S_AXI_rready
);

    localparam int IW = $clog2(DEPTH);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(4 * DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Extra top bit makes addresses below BASE_ADDR wrap far out of range.
    function automatic logic [ADDR_WIDTH:0] addr_off(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} - {1'b0, BASE_ADDR};
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return addr_off(a) < SPAN;
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IW'(addr_off(a) >> 2);
    endfunction

    function automatic logic bad_burst(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || burst[1];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + ADDR_WIDTH'(4);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic     live;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [7:0]            w_cnt;
    logic [1:0]            w_burst;
    logic                  w_bad;
    logic                  w_dec;
    logic                  w_slv;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic [1:0]            r_burst;
    logic                  r_bad;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_last_beat;

    assign S_AXI_awready = live && (w_state == W_IDLE);
    assign S_AXI_wready  = (w_state == W_DATA);
    assign S_AXI_bvalid  = (w_state == W_RESP);
    assign S_AXI_arready = live && (r_state == R_IDLE);
    assign S_AXI_rvalid  = (r_state == R_DATA);

    assign aw_hs = S_AXI_awvalid && S_AXI_awready;
    assign w_hs  = S_AXI_wvalid && S_AXI_wready;
    assign b_hs  = S_AXI_bvalid && S_AXI_bready;
    assign ar_hs = S_AXI_arvalid && S_AXI_arready;
    assign r_hs  = S_AXI_rvalid && S_AXI_rready;

    assign w_last_beat = (w_cnt == w_len);

    always_comb begin
        S_AXI_bresp = RESP_OKAY;
        if (w_state == W_RESP) begin
            if (w_dec)
                S_AXI_bresp = RESP_DECERR;
            else if (w_slv)
                S_AXI_bresp = RESP_SLVERR;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            live    <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            live    <= 1'b1;
        end
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: if (aw_hs) w_next = W_DATA;
            W_DATA: if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP: if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (ar_hs) r_next = R_DATA;
            R_DATA: if (r_hs && S_AXI_rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            w_bad   <= 1'b0;
            w_dec   <= 1'b0;
            w_slv   <= 1'b0;
        end else if (aw_hs) begin
            w_addr  <= S_AXI_awaddr;
            w_len   <= S_AXI_awlen;
            w_cnt   <= '0;
            w_burst <= S_AXI_awburst;
            w_bad   <= bad_burst(S_AXI_awsize, S_AXI_awburst);
            w_dec   <= 1'b0;
            w_slv   <= bad_burst(S_AXI_awsize, S_AXI_awburst);
        end else if (w_hs) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= next_addr(w_addr, w_burst);
            if (!in_range(w_addr))
                w_dec <= 1'b1;
            if (S_AXI_wlast != w_last_beat)
                w_slv <= 1'b1;
        end
    end

    // RAM contents survive reset; only the beat in flight is gated.
    always_ff @(posedge ACLK) begin
        if (!ARESET && w_hs && !w_bad && in_range(w_addr)) begin
            for (int b = 0; b < SW; b++) begin
                if (S_AXI_wstrb[b])
                    mem[word_idx(w_addr)][8*b +: 8] <= S_AXI_wdata[8*b +: 8];
            end
        end
    end

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_bad;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic [1:0]            fetch_resp;

    // Fetch comes from AR in idle, else from the next beat address.
    always_comb begin
        rd_addr    = (r_state == R_IDLE) ? S_AXI_araddr : r_addr;
        rd_bad     = (r_state == R_IDLE) ? bad_burst(S_AXI_arsize, S_AXI_arburst) : r_bad;
        rd_word    = mem[word_idx(rd_addr)];
        fetch_data = '0;
        fetch_resp = RESP_OKAY;
        if (rd_bad)
            fetch_resp = RESP_SLVERR;
        else if (!in_range(rd_addr))
            fetch_resp = RESP_DECERR;
        else
            fetch_data = rd_word;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_burst     <= '0;
            r_bad       <= 1'b0;
            S_AXI_rdata <= '0;
            S_AXI_rresp <= RESP_OKAY;
            S_AXI_rlast <= 1'b0;
        end else if (ar_hs) begin
            r_len       <= S_AXI_arlen;
            r_cnt       <= '0;
            r_burst     <= S_AXI_arburst;
            r_bad       <= bad_burst(S_AXI_arsize, S_AXI_arburst);
            r_addr      <= next_addr(S_AXI_araddr, S_AXI_arburst);
            S_AXI_rdata <= fetch_data;
            S_AXI_rresp <= fetch_resp;
            S_AXI_rlast <= (S_AXI_arlen == 8'd0);
        end else if (r_hs) begin
            if (S_AXI_rlast) begin
                S_AXI_rlast <= 1'b0;
            end else begin
                r_cnt       <= r_cnt + 8'd1;
                r_addr      <= next_addr(r_addr, r_burst);
                S_AXI_rdata <= fetch_data;
                S_AXI_rresp <= fetch_resp;
                S_AXI_rlast <= ((r_cnt + 8'd1) == r_len);
            end
        end
    end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed self-checking bench for axi4_slave_mem.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi4_slave_mem;

    typedef logic [31:0] vec8_t [8];
    typedef logic [1:0]  resp8_t [8];

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    axi4_slave_mem dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .S_AXI_awaddr  (awaddr),
        .S_AXI_awlen   (awlen),
        .S_AXI_awsize  (awsize),
        .S_AXI_awburst (awburst),
        .S_AXI_awvalid (awvalid),
        .S_AXI_awready (awready),
        .S_AXI_wdata   (wdata),
        .S_AXI_wstrb   (wstrb),
        .S_AXI_wlast   (wlast),
        .S_AXI_wvalid  (wvalid),
        .S_AXI_wready  (wready),
        .S_AXI_bresp   (bresp),
        .S_AXI_bvalid  (bvalid),
        .S_AXI_bready  (bready),
        .S_AXI_araddr  (araddr),
        .S_AXI_arlen   (arlen),
        .S_AXI_arsize  (arsize),
        .S_AXI_arburst (arburst),
        .S_AXI_arvalid (arvalid),
        .S_AXI_arready (arready),
        .S_AXI_rdata   (rdata),
        .S_AXI_rresp   (rresp),
        .S_AXI_rlast   (rlast),
        .S_AXI_rvalid  (rvalid),
        .S_AXI_rready  (rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [7:0] len,
                      input logic [1:0] burst, input vec8_t d,
                      input logic [3:0] strb, input int early,
                      output logic [1:0] resp);
        int n;
        awaddr  = addr;
        awlen   = len;
        awsize  = 3'b010;
        awburst = burst;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("aw_timeout", 32'd0, 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata  = d[i];
            wstrb  = strb;
            wlast  = (i == int'(len)) || (i == early);
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) check("w_timeout", 32'd0, 32'd1);
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("b_timeout", 32'd0, 32'd1);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [7:0] len,
                      input logic [1:0] burst, input bit stall,
                      output vec8_t d, output vec8_t sd,
                      output resp8_t r, output logic [7:0] lv);
        int n;
        for (int i = 0; i < 8; i++) begin
            d[i] = '0; sd[i] = '0; r[i] = '0;
        end
        lv      = '0;
        araddr  = addr;
        arlen   = len;
        arsize  = 3'b010;
        arburst = burst;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("ar_timeout", 32'd0, 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("r_latency", 32'(rvalid), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            if (stall && i > 0) begin
                rready = 1'b0;
                @(negedge clk);
                sd[i] = rdata;
            end
            rready = 1'b1;
            n = 0;
            while (!rvalid && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) check("r_timeout", 32'd0, 32'd1);
            d[i]  = rdata;
            r[i]  = rresp;
            lv[i] = rlast;
            @(negedge clk);
        end
        rready = 1'b0;
        check("r_end_valid", 32'(rvalid), 32'd0);
        check("r_end_arready", 32'(arready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec8_t       wd, d, sd, d2, sd2;
        resp8_t      r, r2;
        logic [7:0]  lv, lv2;
        logic [1:0]  br;
        {awaddr, awlen, awsize, awburst, awvalid} = '0;
        {wdata, wstrb, wlast, wvalid, bready}     = '0;
        {araddr, arlen, arsize, arburst, arvalid} = '0;
        rready = 1'b0;
        for (int i = 0; i < 8; i++) wd[i] = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_arready", 32'(arready), 32'd1);

        wd[0] = 32'h1111_1111;
        wr(32'h0, 8'd0, INCR, wd, 4'hF, -1, br);
        check("w0_bresp", 32'(br), 32'd0);

        wd[0] = 32'hDEAD_BEEF;
        wr(32'h10, 8'd0, INCR, wd, 4'hF, -1, br);
        check("single_bresp", 32'(br), 32'd0);
        rd(32'h10, 8'd0, INCR, 1'b0, d, sd, r, lv);
        check("single_rdata", d[0], 32'hDEAD_BEEF);
        check("single_rresp", 32'(r[0]), 32'd0);
        check("single_rlast", 32'(lv[0]), 32'd1);

        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        wr(32'h100, 8'd3, INCR, wd, 4'hF, -1, br);
        check("incr_bresp", 32'(br), 32'd0);
        rd(32'h100, 8'd3, INCR, 1'b1, d, sd, r, lv);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("incr_d%0d", i), d[i], 32'(i + 1));
            check($sformatf("incr_resp%0d", i), 32'(r[i]), 32'd0);
            check($sformatf("incr_last%0d", i), 32'(lv[i]), 32'(i == 3));
            if (i > 0) check($sformatf("incr_hold%0d", i), sd[i], 32'(i + 1));
        end

        wd[0] = 32'hFFFF_FFFF;
        wr(32'h40, 8'd0, INCR, wd, 4'hF, -1, br);
        wd[0] = 32'h0000_0000;
        wr(32'h40, 8'd0, INCR, wd, 4'b0101, -1, br);
        rd(32'h40, 8'd0, INCR, 1'b0, d, sd, r, lv);
        check("strb_rdata", d[0], 32'hFF00_FF00);

        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC;
        wr(32'h20, 8'd2, FIXED, wd, 4'hF, -1, br);
        check("fixed_bresp", 32'(br), 32'd0);
        rd(32'h20, 8'd0, INCR, 1'b0, d, sd, r, lv);
        check("fixed_rdata", d[0], 32'hC);

        wd[0] = 32'h9999_9999;
        wr(32'h1000, 8'd0, INCR, wd, 4'hF, -1, br);
        check("oor_bresp", 32'(br), 32'd3);
        rd(32'h0, 8'd0, INCR, 1'b0, d, sd, r, lv);
        check("oor_unchanged", d[0], 32'h1111_1111);

        rd(32'h10, 8'd0, WRAP, 1'b0, d, sd, r, lv);
        check("wrap_rresp", 32'(r[0]), 32'd2);
        check("wrap_rdata", d[0], 32'd0);

        wd[0] = 32'hCAFE_F00D;
        wr(32'hFFC, 8'd0, INCR, wd, 4'hF, -1, br);
        rd(32'hFFC, 8'd1, INCR, 1'b0, d, sd, r, lv);
        check("top_d0", d[0], 32'hCAFE_F00D);
        check("top_resp0", 32'(r[0]), 32'd0);
        check("top_resp1", 32'(r[1]), 32'd3);
        check("top_d1", d[1], 32'd0);
        check("top_last", 32'(lv[1:0]), 32'd2);

        wd[0] = 32'h5; wd[1] = 32'h6; wd[2] = 32'h7;
        wr(32'h80, 8'd2, INCR, wd, 4'hF, 0, br);
        check("early_wlast_bresp", 32'(br), 32'd2);
        rd(32'h80, 8'd2, INCR, 1'b0, d, sd, r, lv);
        check("early_d0", d[0], 32'h5);
        check("early_d2", d[2], 32'h7);

        araddr  = 32'h100;
        arlen   = 8'd3;
        arsize  = 3'b010;
        arburst = INCR;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        rready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_beat2", rdata, 32'd3);
        rready = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_arready", 32'(arready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rel_arready", 32'(arready), 32'd1);
        rd(32'h10, 8'd0, INCR, 1'b0, d, sd, r, lv);
        check("mid_rst_new_read", d[0], 32'hDEAD_BEEF);

        wd[0] = 32'h1234_5678;
        fork
            wr(32'h200, 8'd0, INCR, wd, 4'hF, -1, br);
            rd(32'h100, 8'd1, INCR, 1'b0, d2, sd2, r2, lv2);
        join
        check("conc_bresp", 32'(br), 32'd0);
        check("conc_rd0", d2[0], 32'd1);
        check("conc_rd1", d2[1], 32'd2);
        rd(32'h200, 8'd0, INCR, 1'b0, d, sd, r, lv);
        check("conc_wr_data", d[0], 32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
